// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit that owns the HI and LO registers.
// MULT/MULTU run a shift-add multiply on operand magnitudes, and DIV/DIVU run
// a restoring divide. Both produce one bit per cycle over 32 CALC cycles,
// followed by one FIXUP cycle that applies the sign correction and writes
// HI/LO. MTHI/MTLO write HI/LO directly while the unit is idle.
// isbusy tells the hazard unit to stall any HI/LO reader or writer in ID.
// Optional feature: define MD_EARLY_TERM_EN to let a multiply leave CALC as
// soon as the remaining multiplier bits are all zero. Divide latency is fixed.
module md_unit #(
    parameter logic [31:0] HILO_RST = 32'h0000_0000,
    parameter int          CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_cancel,
    output logic        isbusy,
    output logic        md_done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    // acc: running product (mul) or partial remainder in [31:0] (div)
    // opa: shifted multiplicand (mul) or dividend/quotient in [31:0] (div)
    // opb: remaining multiplier bits (mul) or divisor magnitude (div)
    logic [63:0]      acc;
    logic [63:0]      opa;
    logic [31:0]      opb;
    logic [31:0]      raw_a;
    logic             sa;
    logic             sb;
    logic             is_div;
    logic             div_zero;

    logic             is_md_op;
    logic             op_signed;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic             accept;

    logic [63:0]      mul_acc_next;
    logic [32:0]      div_shift;
    logic [32:0]      div_diff;
    logic             div_fits;
    logic [31:0]      div_rem_next;
    logic [31:0]      div_quo_next;
    logic             mul_early;
    logic             calc_last;

    logic [63:0]      prod_fix;
    logic [31:0]      quo_fix;
    logic [31:0]      rem_fix;

    // Operand decode and magnitude extraction for the accept cycle
    always_comb begin
        is_md_op  = ~md_op[2];
        op_signed = ~md_op[0];
        a_mag     = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
        b_mag     = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
        accept    = (state == ST_IDLE) && md_start && is_md_op && !md_cancel;
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_acc_next = opb[0] ? (acc + opa) : acc;
        div_shift    = {acc[31:0], opa[31]};
        div_diff     = div_shift - {1'b0, opb};
        div_fits     = ~div_diff[32];
        div_rem_next = div_fits ? div_diff[31:0] : div_shift[31:0];
        div_quo_next = {opa[30:0], div_fits};
`ifdef MD_EARLY_TERM_EN
        mul_early    = !is_div && (opb[31:1] == 31'd0);
`else
        mul_early    = 1'b0;
`endif
        calc_last    = (cnt == CNT_W'(1)) || mul_early;
    end

    // Sign correction applied in the FIXUP cycle
    always_comb begin
        prod_fix = (sa ^ sb) ? (64'd0 - acc) : acc;
        quo_fix  = (sa ^ sb) ? (32'd0 - opa[31:0]) : opa[31:0];
        rem_fix  = sa ? (32'd0 - acc[31:0]) : acc[31:0];
    end

    // Control sequencing: IDLE -> CALC (cnt 32..1) -> FIXUP -> IDLE, cancel aborts
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else if (md_cancel) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (md_start && is_md_op) begin
                        state <= ST_CALC;
                        cnt   <= CNT_W'(32);
                    end
                end
                ST_CALC: begin
                    if (calc_last) begin
                        state <= ST_FIXUP;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt - CNT_W'(1);
                    end
                end
                ST_FIXUP: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Datapath registers: latch magnitudes and signs on accept, iterate in CALC
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            raw_a    <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            acc      <= '0;
            opa      <= {32'd0, a_mag};
            opb      <= b_mag;
            raw_a    <= src_a;
            sa       <= op_signed & src_a[31];
            sb       <= op_signed & src_b[31];
            is_div   <= md_op[1];
            div_zero <= md_op[1] && (src_b == 32'd0);
        end else if (state == ST_CALC && !md_cancel) begin
            if (is_div) begin
                acc <= {32'd0, div_rem_next};
                opa <= {32'd0, div_quo_next};
            end else begin
                acc <= mul_acc_next;
                opa <= {opa[62:0], 1'b0};
                opb <= {1'b0, opb[31:1]};
            end
        end
    end

    // HI/LO writes: zero-latency MTHI/MTLO in IDLE, mul/div results in FIXUP
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= HILO_RST;
            lo_q <= HILO_RST;
        end else if (!md_cancel) begin
            if (state == ST_IDLE && md_start) begin
                if (md_op == OP_MTHI) begin
                    hi_q <= src_a;
                end else if (md_op == OP_MTLO) begin
                    lo_q <= src_a;
                end
            end else if (state == ST_FIXUP) begin
                if (!is_div) begin
                    hi_q <= prod_fix[63:32];
                    lo_q <= prod_fix[31:0];
                end else if (div_zero) begin
                    hi_q <= raw_a;
                    lo_q <= 32'hFFFF_FFFF;
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
            end
        end
    end

    // Output drive; isbusy already rises in the issue cycle of a mul/div
    always_comb begin
        isbusy  = (state != ST_IDLE) || (md_start && is_md_op);
        md_done = done_q;
        hi_out  = hi_q;
        lo_out  = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. Issued mul/div results come from
// an arithmetic reference model and are queued; a monitor pops and compares
// them whenever md_done pulses. Honours MD_EARLY_TERM_EN for expected latency.
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_cancel;
    logic        isbusy;
    logic        md_done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    md_unit dut (
        .clk       (clk),
        .rst       (rst),
        .md_start  (md_start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .md_cancel (md_cancel),
        .isbusy    (isbusy),
        .md_done   (md_done),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    // Free-running clock: posedge at 5, 15, ...; inputs change on negedges
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; every failure prints a single FAIL line
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference result as {HI, LO}, straight from the arithmetic definition
    function automatic logic [63:0] modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa_l, sb_l, q, r;
        logic [63:0] ua, ub;
        sa_l = longint'($signed(a));
        sb_l = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'b000: return 64'(sa_l * sb_l);
            3'b001: return ua * ub;
            3'b010: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa_l / sb_l;
                r = sa_l % sb_l;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Cycles isbusy stays high for a mul/div: issue + CALC + FIXUP
    function automatic int expLatency(input logic [2:0] op, input logic [31:0] b);
        int calc;
        logic [31:0] m;
        calc = 32;
        m = b;
`ifdef MD_EARLY_TERM_EN
        if (op[1] == 1'b0) begin
            m = (op[0] == 1'b0 && b[31]) ? (32'd0 - b) : b;
            calc = 1;
            for (int i = 0; i < 32; i++) if (m[i]) calc = i + 1;
        end
`endif
        if (op[2] || m === 32'hx) calc = 32;
        return calc + 2;
    endfunction

    // Issue one instruction; cancel_cycle counts from 1 = issue cycle, 0 = none
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int cancel_cycle);
        int lat, exp_busy, busy;
        bit idle_seen;
        logic [63:0] res;
        lat = expLatency(op, b);
        if (op[2] == 1'b0) begin
            if (cancel_cycle >= 1 && cancel_cycle <= lat) begin
                exp_busy = cancel_cycle;
            end else begin
                exp_busy = lat;
                res = modelResult(op, a, b);
                exp_q.push_back(res);
                model_hi = res[63:32];
                model_lo = res[31:0];
            end
        end else begin
            exp_busy = 0;
            if (cancel_cycle != 1) begin
                if (op == 3'b100) model_hi = a;
                if (op == 3'b101) model_lo = a;
            end
        end
        @(negedge clk);
        md_start  = 1'b1;
        md_op     = op;
        src_a     = a;
        src_b     = b;
        md_cancel = (cancel_cycle == 1);
        busy = 0;
        idle_seen = 1'b0;
        for (int c = 1; c <= 64 && !idle_seen; c++) begin
            if (c > 1) begin
                @(negedge clk);
                md_start  = 1'b0;
                md_cancel = (cancel_cycle == c);
            end
            #2;
            if (isbusy) busy++;
            else idle_seen = 1'b1;
        end
        if (!idle_seen) checkOutput("busy_timeout", 64'(isbusy), 64'd0);
        @(posedge clk);
        #1;
        md_start  = 1'b0;
        md_cancel = 1'b0;
        checkOutput("busy_cycles", 64'(busy), 64'(exp_busy));
        checkOutput("hilo_after_op", {hi_out, lo_out}, {model_hi, model_lo});
    endtask

    // Monitor: every md_done pulse must match the oldest queued result
    always @(negedge clk) begin
        if (!rst && md_done) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_done", 64'(md_done), 64'd0);
            end else begin
                checkOutput("done_hilo", {hi_out, lo_out}, exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, randomized cases, mid-op reset
    initial begin
        int lat, cc, sel;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; md_start = 1'b0; md_op = 3'b000;
        src_a = 32'd0; src_b = 32'd0; md_cancel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", 64'(hi_out), 64'd0);
        checkOutput("reset_lo", 64'(lo_out), 64'd0);
        checkOutput("reset_isbusy", 64'(isbusy), 64'd0);
        checkOutput("reset_done", 64'(md_done), 64'd0);

        applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd5, 0);
        applyStimulus(3'b001, 32'hFFFF_FFFD, 32'd5, 0);
        applyStimulus(3'b011, 32'd100, 32'd7, 0);
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2, 0);
        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus(3'b011, 32'h0000_1234, 32'd0, 0);
        applyStimulus(3'b010, 32'hFFFF_FF00, 32'd0, 0);
        lat = expLatency(3'b000, 32'd9);
        applyStimulus(3'b000, 32'd7, 32'd9, (lat < 11) ? lat - 1 : 11);
        applyStimulus(3'b000, 32'd7, 32'd9, lat);
        applyStimulus(3'b101, 32'h0000_00AA, 32'd0, 1);
        applyStimulus(3'b100, 32'hDEAD_BEEF, 32'd0, 0);
        applyStimulus(3'b101, 32'h0000_0001, 32'd0, 0);
        applyStimulus(3'b001, 32'h0000_0010, 32'd3, 0);
        applyStimulus(3'b110, 32'h5555_5555, 32'd3, 0);
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(0, 6));
            if (rop == 3'd6) rop = 3'($urandom_range(6, 7));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(0, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            cc = 0;
            if ($urandom_range(0, 5) == 0) begin
                cc = (rop[2] == 1'b0) ? $urandom_range(1, expLatency(rop, rb)) : 1;
            end
            applyStimulus(rop, ra, rb, cc);
        end

        @(negedge clk);
        md_start = 1'b1; md_op = 3'b000; src_a = 32'd123; src_b = 32'd456;
        @(negedge clk);
        md_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        #2;
        checkOutput("midop_reset_isbusy", 64'(isbusy), 64'd0);
        checkOutput("midop_reset_hilo", {hi_out, lo_out}, {model_hi, model_lo});
        repeat (40) @(negedge clk);
        checkOutput("midop_reset_done", 64'(md_done), 64'd0);
        checkOutput("pending_results", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO registers. It is the responder to the hazard unit's isbusy/RHL_visit interlock.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
- Raises isbusy while a result is pending, so the hazard unit stalls any HI/LO reader or writer in ID.
- Drives hi_out/lo_out to the EX-stage MFHI/MFLO path.

Parameters:
- HILO_RST, 32'h0000_0000, reset value of HI and LO.
- CNT_W, 6, width of the iteration counter; must hold values 0..32.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- md_start  in  1  one-cycle pulse per issued HI/LO-writing instruction; the issuer never repeats it for a stalled instruction
- md_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others ignored
- src_a  in  32  rs operand (multiplicand / dividend / MTxx data)
- src_b  in  32  rt operand (multiplier / divisor)
- md_cancel  in  1  issuing instruction was flushed before commit; abort the in-flight op
- isbusy  out  1  result pending; consumed by the stall unit
- md_done  out  1  one-cycle pulse on the cycle HI/LO are written by a mul/div
- hi_out  out  32  current HI register
- lo_out  out  32  current LO register

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - state=IDLE, cnt=0
  - HI=LO=HILO_RST
  - md_done=0
  - internal accumulators=0
- isbusy is combinational: (state!=IDLE) | (md_start & md_op∈{000..011}). It is therefore already high in the issue cycle, so an MFHI directly behind in ID stalls.
- States:
  - IDLE: waiting for an op.
  - CALC: one iteration per cycle while cnt counts 32 down to 1.
  - FIXUP: one cycle; applies sign correction and writes HI/LO; md_done=1; next state IDLE.
- Accept in IDLE with mul/div op:
  - Latch |src_a|, |src_b| (magnitude only for signed ops).
  - Latch sign flags sa = src_a[31] & signed, sb = src_b[31] & signed.
  - cnt=32, next state CALC.
- Multiply: shift-add on magnitudes, producing a 64-bit unsigned product. If sa^sb, negate the product in FIXUP. Result: HI=product[63:32], LO=product[31:0].
- Divide: restoring, 1 quotient bit per cycle. In FIXUP:
  - quotient negated if sa^sb
  - remainder negated if sa
  - LO=quotient, HI=remainder
- Divide by zero (src_b==0 at accept):
  - LO=32'hFFFF_FFFF, HI=src_a (raw, unsigned fixup skipped).
  - Same latency as a normal divide.
- Signed 0x8000_0000 / 0xFFFF_FFFF yields LO=0x8000_0000, HI=0; no trap.
- Latency: accept edge, then 32 CALC cycles, then 1 FIXUP cycle. HI/LO are visible 34 cycles after the accept cycle, counting the accept cycle as 1. isbusy is high for those 34 cycles and low in the cycle after FIXUP.
- MTHI/MTLO in IDLE: write HI/LO at that edge, zero latency, isbusy not raised.
- md_start in any state other than IDLE: ignored. The hazard unit guarantees this never occurs.
- md_cancel:
  - Highest priority in every state: next state IDLE, cnt=0, HI/LO unchanged, md_done=0.
  - A md_start in the same cycle as md_cancel is discarded, including MTHI/MTLO.
  - Cancel during FIXUP suppresses the write.
- rst has priority over md_cancel and md_start; reset mid-operation returns everything to reset values.
- Unknown md_op with md_start: no effect.

Optional Feature:
- Macro: MD_EARLY_TERM_EN
- Defined: for MULT/MULTU, CALC exits to FIXUP once the remaining unshifted multiplier bits are all zero. CALC takes max(1, msb_index(|b|)+1) cycles; b==0 takes 1 CALC cycle. Divide latency is unchanged.
- Undefined: every mul/div spends exactly 32 CALC cycles.

Test Plan:
- Reset, then idle -> hi_out=lo_out=0, isbusy=0, md_done=0.
- MULT src_a=0xFFFF_FFFD (-3), src_b=5 -> isbusy high 34 cycles; md_done pulses once; HI=0xFFFF_FFFF, LO=0xFFFF_FFF1. MULTU with the same operands -> HI=4, LO=0xFFFF_FFF1.
- DIVU 100/7 -> LO=14, HI=2. DIV 0xFFFF_FFF9 (-7)/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- DIVU 0x1234/0 -> LO=0xFFFF_FFFF, HI=0x1234 after the normal 34-cycle latency.
- MULT 7*9 with md_cancel asserted at CALC cycle 10 (also repeat with cancel during FIXUP) -> isbusy drops next cycle; HI/LO keep prior values; md_done never pulses. md_start+md_cancel with MTLO 0xAA -> LO unchanged.
- MTHI 0xDEAD_BEEF then MTLO 0x1 on consecutive cycles -> HI/LO updated at each edge; isbusy stays 0. With MD_EARLY_TERM_EN, MULTU 0x10*3 -> HI:LO=0x30 after 2 CALC cycles, total busy 4 cycles.
